// File: rtl/ann_pkg.sv
// Shared ANN datapath constants and types used by the layer sequencer.
package ann_pkg;

  localparam int unsigned neuron_size       = 2;
  localparam int unsigned word_size         = 16;
  localparam int unsigned NumNeuronsDefault = 4;

  typedef logic [neuron_size-1:0][word_size-1:0] vec_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } seq_state_t;

endpackage

// File: rtl/layer_sequencer_capture.sv
// Operand/capture delay pipeline, capture counter and output register file.
// Optional ReLU on captured results is enabled with the ANN_RELU_EN macro.
module layer_sequencer_capture
  import ann_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = NumNeuronsDefault,
  parameter int unsigned AW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   clr,
  input  logic                                   start,
  input  logic                                   rd,
  input  logic [word_size-1:0]                   result,
  output logic                                   en,
  output logic                                   last,
  output logic [NUM_NEURONS-1:0][word_size-1:0]  y
);

  localparam logic [AW-1:0] LastIdx = AW'(NUM_NEURONS - 1);

  logic                                  en_q;
  logic                                  cap_q;
  logic [AW-1:0]                         cap_cnt_q;
  logic [word_size-1:0]                  cap_val;
  logic [NUM_NEURONS-1:0][word_size-1:0] y_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q  <= 1'b0;
      cap_q <= 1'b0;
    end else if (clr) begin
      en_q  <= 1'b0;
      cap_q <= 1'b0;
    end else begin
      en_q  <= rd;
      cap_q <= en_q;
    end
  end

  // Saturates on the last row so the index never leaves the register file.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cap_cnt_q <= '0;
    end else if (start) begin
      cap_cnt_q <= '0;
    end else if (cap_q && !clr && (cap_cnt_q != LastIdx)) begin
      cap_cnt_q <= cap_cnt_q + 1'b1;
    end
  end

`ifdef ANN_RELU_EN
  assign cap_val = result[word_size-1] ? '0 : result;
`else
  assign cap_val = result;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      y_q <= '0;
    end else if (cap_q && !clr) begin
      y_q[cap_cnt_q] <= cap_val;
    end
  end

  assign en   = en_q;
  assign last = cap_q && (cap_cnt_q == LastIdx);
  assign y    = y_q;

endmodule

// File: rtl/layer_sequencer.sv
// Time-multiplexes one neuron datapath across all outputs of a fully connected layer.
// Define ANN_RELU_EN to clamp negative neuron results to zero on capture.
module layer_sequencer
  import ann_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = NumNeuronsDefault,
  parameter int unsigned AW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   clr_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  vec_t                                   x_i,
  output logic                                   wmem_rd_o,
  output logic [AW-1:0]                          wmem_addr_o,
  input  vec_t                                   wmem_data_i,
  output logic                                   neu_en_o,
  output vec_t                                   neu_x_o,
  output vec_t                                   neu_w_o,
  input  logic [word_size-1:0]                   neu_result_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [NUM_NEURONS-1:0][word_size-1:0]  y_o,
  output logic                                   busy_o
);

  localparam logic [AW-1:0] LastIdx = AW'(NUM_NEURONS - 1);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] issue_cnt_q;
  vec_t          neu_x_q;
  logic          accept;
  logic          cap_last;

  assign accept = (state_q == StIdle) && in_valid_i && !clr_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (in_valid_i) state_d = StRun;
        StRun:   if (issue_cnt_q == LastIdx) state_d = StDrain;
        StDrain: if (cap_last) state_d = StDone;
        StDone:  if (out_ready_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    wmem_rd_o   = (state_q == StRun);
    wmem_addr_o = wmem_rd_o ? issue_cnt_q : '0;
    out_valid_o = (state_q == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      issue_cnt_q <= '0;
    end else if (accept) begin
      issue_cnt_q <= '0;
    end else if ((state_q == StRun) && (issue_cnt_q != LastIdx)) begin
      issue_cnt_q <= issue_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      neu_x_q <= '0;
    end else if (accept) begin
      neu_x_q <= x_i;
    end
  end

  assign neu_x_o = neu_x_q;
  assign neu_w_o = wmem_data_i;

  layer_sequencer_capture #(
    .NUM_NEURONS (NUM_NEURONS),
    .AW          (AW)
  ) u_capture (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr     (clr_i),
    .start   (accept),
    .rd      (wmem_rd_o),
    .result  (neu_result_i),
    .en      (neu_en_o),
    .last    (cap_last),
    .y       (y_o)
  );

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer with a cycle-timeline reference model.
module tb_layer_sequencer;
  import ann_pkg::*;

  localparam int N = 4;
`ifdef ANN_RELU_EN
  localparam logic [15:0] ReluExp = 16'h0000;
`else
  localparam logic [15:0] ReluExp = 16'hFFF0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (N=4)
  logic               clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic               in_ready, wmem_rd, neu_en, out_valid, busy;
  logic [1:0]         wmem_addr;
  vec_t               x_in = '0, wmem_data = '0, neu_x, neu_w;
  logic [15:0]        neu_result = '0;
  logic [N-1:0][15:0] y;

  layer_sequencer #(.NUM_NEURONS(N)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .x_i(x_in), .wmem_rd_o(wmem_rd), .wmem_addr_o(wmem_addr),
    .wmem_data_i(wmem_data), .neu_en_o(neu_en), .neu_x_o(neu_x), .neu_w_o(neu_w),
    .neu_result_i(neu_result), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y_o(y), .busy_o(busy)
  );

  // Second DUT (N=1)
  logic        iv1 = 1'b0, or1 = 1'b1;
  logic        rdy1, rd1, en1, ov1, busy1;
  logic [0:0]  addr1, last_addr1 = 1'b1;
  vec_t        x1 = {16'd3, 16'd2}, wd1 = '0, nx1, nw1;
  logic [15:0] res1 = '0;
  logic [0:0][15:0] y1;
  int          rd1_cnt = 0;

  layer_sequencer #(.NUM_NEURONS(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(1'b0), .in_valid_i(iv1),
    .in_ready_o(rdy1), .x_i(x1), .wmem_rd_o(rd1), .wmem_addr_o(addr1),
    .wmem_data_i(wd1), .neu_en_o(en1), .neu_x_o(nx1), .neu_w_o(nw1),
    .neu_result_i(res1), .out_valid_o(ov1), .out_ready_i(or1),
    .y_o(y1), .busy_o(busy1)
  );

  int checks = 0;
  int failures = 0;
  vec_t w_mem [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] dot(input vec_t a, input vec_t b);
    int acc = 0;
    for (int i = 0; i < neuron_size; i++) acc += int'($signed(a[i])) * int'($signed(b[i]));
    return acc[15:0];
  endfunction

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef ANN_RELU_EN
    return v[15] ? 16'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [N-1:0][15:0] layer_out(input vec_t xv);
    logic [N-1:0][15:0] r;
    for (int k = 0; k < N; k++) r[k] = relu(dot(xv, w_mem[k]));
    return r;
  endfunction

  // Environment: synchronous weight memory and a 1-cycle registered neuron.
  always @(posedge clk) begin
    if (wmem_rd) wmem_data <= w_mem[wmem_addr];
    if (neu_en) neu_result <= dot(neu_x, neu_w);
    if (rd1) begin
      wd1 <= {16'd4, 16'd1};
      rd1_cnt <= rd1_cnt + 1;
      last_addr1 <= addr1;
    end
    if (en1) res1 <= dot(nx1, nw1);
  end

  // Reference model: m_t counts cycles since the accept edge (cycle A+m_t).
  logic               m_busy = 1'b0;
  int                 m_t = 0;
  vec_t               m_x = '0;
  logic [N-1:0][15:0] m_y = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else if (clr) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_t    <= 1;
        m_x    <= x_in;
        m_y    <= layer_out(x_in);
      end
    end else if (m_t >= N + 3) begin
      if (out_ready) begin
        m_busy <= 1'b0;
        m_t    <= 0;
      end
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic rd_e, en_e, ov_e;
  always @(negedge clk) begin
    if (rst_n) begin
      rd_e = m_busy && (m_t >= 1) && (m_t <= N);
      en_e = m_busy && (m_t >= 2) && (m_t <= N + 1);
      ov_e = m_busy && (m_t >= N + 3);
      check("in_ready", in_ready, !m_busy);
      check("busy", busy, m_busy);
      check("wmem_rd", wmem_rd, rd_e);
      check("wmem_addr", wmem_addr, rd_e ? m_t - 1 : 0);
      check("neu_en", neu_en, en_e);
      check("out_valid", out_valid, ov_e);
      if (ov_e) check("y_model", y, m_y);
      if (m_busy) check("neu_x", neu_x, m_x);
      if (en_e) check("neu_w", neu_w, w_mem[m_t - 2]);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int cyc, clr_at, hold_ok;
  logic do_clr, done;
  logic [N-1:0][15:0] y_snap;

  initial begin
    for (int k = 0; k < N; k++) w_mem[k] = '0;
    // Reset values
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rd_en", {wmem_rd, neu_en}, 2'b00);
    check("rst_addr", wmem_addr, 0);
    check("rst_y", y, 0);
    check("rst_neu_x", neu_x, 0);
    rst_n = 1'b1;
    tick();

    // Directed layer: x={3,2}, row k={k,1} -> y[k]=3k+2
    for (int k = 0; k < N; k++) w_mem[k] = {16'(k), 16'd1};
    x_in = {16'd3, 16'd2};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x_in = '0;
    cyc = 1;
    while (!out_valid && cyc < 30) begin tick(); cyc++; end
    check("dir_ov_cycle", cyc, 7);
    check("dir_y", y, 64'h000B_0008_0005_0002);
    y_snap = y;
    in_valid = 1'b1;
    hold_ok = 1;
    repeat (5) begin
      tick();
      if (y !== y_snap || in_ready !== 1'b0) hold_ok = 0;
    end
    check("dir_hold_stable", hold_ok, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("dir_ready_after_hs", in_ready, 1'b1);

    // clr in cycle A+3
    x_in = $urandom;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_idle", {busy, in_ready}, 2'b01);
    hold_ok = 1;
    repeat (8) begin tick(); if (out_valid !== 1'b0) hold_ok = 0; end
    check("clr_no_out_valid", hold_ok, 1);

    // Random layers with random aborts and downstream stalls
    for (int l = 0; l < 40; l++) begin
      for (int k = 0; k < N; k++) w_mem[k] = $urandom;
      x_in = $urandom;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      do_clr = ($urandom_range(0, 4) == 0);
      clr_at = $urandom_range(1, N + 4);
      cyc = 1;
      done = 1'b0;
      while (!done) begin
        if (do_clr && cyc == clr_at) begin
          clr = 1'b1;
          tick();
          clr = 1'b0;
          done = 1'b1;
        end else if (out_valid) begin
          done = 1'b1;
          repeat ($urandom_range(0, 3)) tick();
          out_ready = 1'b1;
          tick();
          out_ready = 1'b0;
        end else if (cyc > 30) begin
          check("rand_timeout", out_valid, 1'b1);
          done = 1'b1;
        end else begin
          x_in = $urandom;
          tick();
          cyc++;
        end
      end
    end

    // Negative result: ReLU clamps, raw otherwise
    for (int k = 0; k < N; k++) w_mem[k] = {16'd1, 16'd0};
    x_in = {16'hFFF0, 16'd0};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 30) begin tick(); cyc++; end
    check("relu_y0", y[0], ReluExp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Async reset while in DRAIN
    x_in = {16'd3, 16'd2};
    for (int k = 0; k < N; k++) w_mem[k] = {16'(k), 16'd1};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (N) tick();
    check("drain_busy", {busy, wmem_rd, out_valid}, 3'b100);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready_busy", {in_ready, busy}, 2'b10);
    check("arst_rd_en_ov", {wmem_rd, neu_en, out_valid}, 3'b000);
    check("arst_addr", wmem_addr, 0);
    check("arst_y", y, 0);
    check("arst_neu_x", neu_x, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // N=1 instance: one read at address 0, out_valid in A+4, y = 3*4+2
    rd1_cnt = 0;
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    cyc = 1;
    while (!ov1 && cyc < 30) begin tick(); cyc++; end
    check("n1_ov_cycle", cyc, 4);
    check("n1_reads", rd1_cnt, 1);
    check("n1_addr", last_addr1, 0);
    check("n1_y", y1, 16'd14);
    tick();
    check("n1_idle", {rdy1, busy1}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Time-multiplexes one `neuron` datapath across all NUM_NEURONS outputs of a fully connected layer. It accepts an input vector over a valid/ready handshake and streams one weight row per cycle from a synchronous weight memory into the neuron. It captures each registered neuron result into an output vector and presents that vector downstream over a second valid/ready handshake. It sits between the previous layer (or the input buffer) and the next layer in the ANN pipeline.

## Interface
- NUM_NEURONS, default 4: outputs per layer (≥1); also the number of weight-memory rows.
- AW, default $clog2(NUM_NEURONS) (minimum 1): weight-memory address width.
- `neuron_size` and `word_size` come from `ann_pkg`.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous abort; returns to IDLE.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  high only in IDLE.
- x_i  in  [neuron_size][word_size]  input vector.
- wmem_rd_o  out  1  weight read strobe.
- wmem_addr_o  out  AW  weight row index.
- wmem_data_i  in  [neuron_size][word_size]  weight row, valid one cycle after the strobe.
- neu_en_o  out  1  neuron operand valid.
- neu_x_o  out  [neuron_size][word_size]  latched input vector.
- neu_w_o  out  [neuron_size][word_size]  equals wmem_data_i, combinational.
- neu_result_i  in  word_size  registered neuron result (1-cycle latency).
- out_valid_o  out  1  output vector valid.
- out_ready_i  in  1  downstream accept.
- y_o  out  [NUM_NEURONS][word_size]  output vector.
- busy_o  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready_o=1. If in_valid_i is high, latch x_i into neu_x_o, clear both counters, and go to RUN.
- RUN: wmem_rd_o=1, wmem_addr_o=issue_cnt, issue_cnt increments each cycle. Go to DRAIN after issuing address NUM_NEURONS-1.
- Operand stage: a one-cycle-delayed copy of wmem_rd_o drives neu_en_o.
- Capture stage: a one-cycle-delayed copy of neu_en_o writes neu_result_i into y_o[cap_cnt], then cap_cnt increments.
- DRAIN: no reads are issued. Go to DONE on the cycle the capture of index NUM_NEURONS-1 is written.
- DONE: out_valid_o=1 and y_o is held stable. When out_ready_i is high, go to IDLE.
- Counters do not wrap mid-layer. issue_cnt saturates at NUM_NEURONS-1. Both counters are cleared on accept.
- clr_i has priority over every transition:
  - next state IDLE;
  - pipeline valid bits cleared;
  - y_o retained;
  - out_valid_o low next cycle.
- Async reset mid-operation has the same effect as clr_i, and additionally clears y_o and neu_x_o.
- Reset values:
  - in_ready_o=1 (IDLE decode);
  - busy_o, out_valid_o, wmem_rd_o, neu_en_o = 0;
  - wmem_addr_o = 0;
  - y_o and neu_x_o all zero.
- Arithmetic: words are signed two's complement, word_size bits. Values are stored unchanged except under ANN_RELU_EN.

## Timing
- Accept edge is at the end of cycle A.
- Cycle A+1+k: address k issued, for k = 0..N-1.
- Cycle A+2+k: neu_en_o=1 with row k.
- Cycle A+3+k: neu_result_i valid; y_o[k] is written at the end of that cycle.
- out_valid_o rises in cycle A+N+3.
- Throughput: one neuron per cycle. Back-to-back layers cost N+4 cycles plus the out_ready_i wait, because the next accept cannot happen before the cycle after the DONE handshake.
- in_valid_i is ignored outside IDLE.

## Configuration
- ANN_RELU_EN defined: the capture stage writes `neu_result_i[word_size-1] ? 0 : neu_result_i`.
- ANN_RELU_EN undefined: the capture stage writes neu_result_i raw.
- No latency difference between the two.

## Structure
- `ann_pkg` gains:
  - NUM_NEURONS default constant;
  - `seq_state_t` enum (IDLE, RUN, DRAIN, DONE);
  - `vec_t` typedef: `logic [neuron_size-1:0][word_size-1:0]`.
- The `neuron` instance stays outside this block.
- A natural sub-module is `seq_capture`: the delay pipeline, capture counter, optional ReLU, and the y_o register file.

## Test plan
- N=4, neuron_size=2, word_size=16, x={3,2}, weights row k={k,1}, result = 3k+2:
  - in_valid_i pulsed in cycle 0;
  - out_valid_o rises in cycle 7;
  - y_o = {2, 5, 8, 11}.
- Hold out_ready_i=0 for 5 cycles in DONE:
  - y_o is stable;
  - in_ready_o=0 and a new in_valid_i is ignored;
  - after out_ready_i=1, in_ready_o rises the next cycle.
- clr_i asserted in cycle A+3:
  - IDLE next cycle;
  - out_valid_o is never raised;
  - the next layer produces correct results.
- Async reset in DRAIN: all outputs return to their reset values immediately.
- ANN_RELU_EN defined, neu_result_i = 0xFFF0: y = 0. Undefined: y = 0xFFF0.
- N=1: exactly one read, address 0; out_valid_o in cycle A+4.
